stack_seq_ctrl: RTL

- Multi-cycle sequencer for all stack-based control transfers in the RISC core: CALL, RET, hardware interrupt (INT) and RTI.
- Arbitrates the four requesters for the single 16-bit data-memory port and the stack pointer (SP).
- Stalls the pipeline while a sequence runs, then drives the PC (and flags) load.
- Sits between the decode/interrupt logic and the memory stage.

---
 rtl/stack_seq_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/stack_seq_ctrl.sv
// Stack sequencer for CALL / RET / INT / RTI control transfers.
// Owns the stack pointer and the data-memory port while a sequence runs.
module stack_seq_ctrl #(
   parameter int                ADDR_W     = 32,
   parameter int                PC_W       = 32,
   parameter logic [ADDR_W-1:0] SP_INIT    = 32'h0000_0FFF,
   parameter logic [PC_W-1:0]   INT_VECTOR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              int_req,
   input  logic              call_req,
   input  logic              ret_req,
   input  logic              rti_req,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [PC_W-1:0]   target_pc,
   input  logic [3:0]        flags_in,
   input  logic [15:0]       mem_rdata,
   output logic              stall,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic [ADDR_W-1:0] sp_out,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_next,
   output logic              flags_load,
   output logic [3:0]        flags_out,
   output logic              int_ack,
   output logic              done
);

   typedef enum logic [3:0] {
      IDLE,
      C_HI, C_LO, C_JMP,
      I_FL, I_HI, I_LO, I_JMP,
      R_P0, R_P1, R_LD,
      T_P0, T_P1, T_P2, T_LD
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] sp;
   logic              int_pending;
   logic [PC_W-1:0]   pc_reg, tgt_reg;
   logic [3:0]        flags_reg;
   logic [15:0]       lo_reg, hi_reg;

   logic take_int, any_req, accept, accept_int, push, pop;

   // Interrupts (latched or arriving now) win over every level request.
   assign take_int   = int_pending | int_req;
   assign any_req    = take_int | rti_req | call_req | ret_req;
   assign accept     = (state == IDLE) && any_req;
   assign accept_int = (state == IDLE) && take_int;
   assign sp_out     = sp;

   always_comb begin
      state_nxt  = state;
      stall      = 1'b1;
      push       = 1'b0;
      pop        = 1'b0;
      mem_wdata  = '0;
      pc_load    = 1'b0;
      pc_next    = '0;
      flags_load = 1'b0;
      flags_out  = '0;
      int_ack    = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            stall = any_req;
            if (take_int)      state_nxt = I_FL;
            else if (rti_req)  state_nxt = T_P0;
            else if (call_req) state_nxt = C_HI;
            else if (ret_req)  state_nxt = R_P0;
         end
         C_HI: begin push = 1'b1; mem_wdata = pc_reg[31:16]; state_nxt = C_LO; end
         C_LO: begin push = 1'b1; mem_wdata = pc_reg[15:0];  state_nxt = C_JMP; end
         C_JMP: begin
            pc_load = 1'b1; pc_next = tgt_reg; done = 1'b1; state_nxt = IDLE;
         end
         I_FL: begin push = 1'b1; mem_wdata = {12'b0, flags_reg}; state_nxt = I_HI; end
         I_HI: begin push = 1'b1; mem_wdata = pc_reg[31:16];      state_nxt = I_LO; end
         I_LO: begin push = 1'b1; mem_wdata = pc_reg[15:0];       state_nxt = I_JMP; end
         I_JMP: begin
            pc_load = 1'b1; pc_next = INT_VECTOR; flags_load = 1'b1;
            int_ack = 1'b1; done = 1'b1; state_nxt = IDLE;
         end
         R_P0: begin pop = 1'b1; state_nxt = R_P1; end
         R_P1: begin pop = 1'b1; state_nxt = R_LD; end
         // Read data arrives one cycle late, so the last popped word is used live.
         R_LD: begin
            pc_load = 1'b1; pc_next = {mem_rdata, lo_reg}; done = 1'b1; state_nxt = IDLE;
         end
         T_P0: begin pop = 1'b1; state_nxt = T_P1; end
         T_P1: begin pop = 1'b1; state_nxt = T_P2; end
         T_P2: begin pop = 1'b1; state_nxt = T_LD; end
         T_LD: begin
            pc_load = 1'b1; pc_next = {hi_reg, lo_reg}; flags_load = 1'b1;
            flags_out = mem_rdata[3:0]; done = 1'b1; state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      mem_we   = push;
      mem_re   = pop;
      mem_addr = push ? sp : (pop ? sp + ADDR_W'(1) : '0);
   end

   // Aborting via reset simply forgets any partially pushed frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sp          <= SP_INIT;
         int_pending <= 1'b0;
         pc_reg      <= '0;
         tgt_reg     <= '0;
         flags_reg   <= '0;
         lo_reg      <= '0;
         hi_reg      <= '0;
      end else begin
         state       <= state_nxt;
         int_pending <= take_int & ~accept_int;
         if (push)     sp <= sp - ADDR_W'(1);
         else if (pop) sp <= sp + ADDR_W'(1);
         if (accept) begin
            pc_reg    <= pc_in;
            tgt_reg   <= target_pc;
            flags_reg <= flags_in;
         end
         if (state == R_P1 || state == T_P1) lo_reg <= mem_rdata;
         if (state == T_P2)                  hi_reg <= mem_rdata;
      end
   end

endmodule
